counter_days_months: RTL and testbench
======================================

Name: counter_days_months

Overview:
- Day-of-month and month counter for the Millennium Clock calendar chain.
- Sits between the daily tick source and counter_years, and is the producer of the `tick_year` pulse that counter_years consumes.
- Run mode: advances the date on `tick_day`, is leap-year aware using the BCD year digits fed back from counter_years, and emits `tick_year` on the Dec 31 -> Jan 1 rollover.
- Edit mode: the user steps the day or month with `up`/`down`.

Parameters:
- DAY_INIT, 1, day loaded on reset (1..31, BCD-split internally).
- MONTH_INIT, 1, month loaded on reset (1..12).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mode_date  input  1  1 = run (count `tick_day`), 0 = edit (`up`/`down` active).
- edit_sel  input  1  edit target: 0 = day, 1 = month; ignored in run mode.
- up  input  1  level; increments the edit target once per clock while asserted.
- down  input  1  level; decrements the edit target once per clock while asserted.
- tick_day  input  1  level; one day advance per clock while asserted, run mode only.
- year_unit, year_ten, year_hundered, year_thousand  input  4 each  BCD year from counter_years.
- day_unit  output  4  BCD day units (0..9).
- day_ten  output  4  BCD day tens (0..3).
- month_unit  output  4  BCD month units (0..9).
- month_ten  output  4  BCD month tens (0..1).
- tick_year  output  1  registered one-cycle pulse on year rollover.

Behaviour:
- Reset (async assert, any time, including mid-rollover):
  - Outputs go to DAY_INIT/MONTH_INIT in BCD; defaults give 01/01.
  - `tick_year` = 0.
  - Release is synchronous to clk.
- All outputs are registered; a change appears on the clock edge that samples the input (1-cycle latency).
- Leap year, combinational from BCD:
  - yy = year_ten:year_unit, hh = year_thousand:year_hundered.
  - A two-digit BCD value is divisible by 4 iff (tens even and units in {0,4,8}) or (tens odd and units in {2,6}).
  - leap = (yy != 00 and yy div 4) or (yy == 00 and hh div 4).
  - Examples: 2000 leap, 1900 not, 2024 leap, 2023 not.
- Days in month (dim):
  - 31 for months 1,3,5,7,8,10,12.
  - 30 for months 4,6,9,11.
  - 29 for month 2 when leap, else 28.
- Run mode (mode_date = 1; `up`, `down`, `edit_sel` ignored), per clock with `tick_day` = 1:
  - day < dim: day + 1.
  - day == dim, month < 12: day = 1, month + 1.
  - day == dim, month == 12: day = 1, month = 1, `tick_year` = 1 for exactly that cycle.
  - `tick_day` held high for N cycles advances N days, and can produce consecutive-year pulses separated by 365/366 cycles.
- Edit mode (mode_date = 0; `tick_day` ignored, `tick_year` held 0):
  - up && !down: day wraps dim -> 1; month wraps 12 -> 1, with no `tick_year`.
  - down && !up: day wraps 1 -> dim; month wraps 1 -> 12.
  - up && down, or neither: hold.
- Clamp, evaluated every clock in both modes after the update above:
  - If the resulting day > dim(resulting month, current leap), day = dim.
  - Covers a month edit from 31 into a 30-day month or into Feb.
  - Covers a year change that makes Feb 29 invalid: Feb 29 becomes Feb 28 on the next edge after the year inputs change.
- Mode switch takes effect on the same edge; no state is lost.
- Counter state is always a legal BCD date; illegal digits are never produced.

Test Plan:
- Reset: rst_n = 0 with random inputs, then release -> outputs 0,1,0,1 (01/01), `tick_year` = 0; assert rst_n asynchronously mid-count -> immediate return to 01/01.
- Year rollover: year = 2023, mode_date = 1, `tick_day` held 365 cycles from 01/01 -> date back at 01/01 and `tick_year` high for exactly one cycle, on the 365th edge; with year = 2024 the pulse comes on the 366th edge and 02/29 is visited.
- Leap rules: Feb 28, one tick, years 1900 / 2000 / 2100 / 2400 -> 03/01, 02/29, 03/01, 02/29.
- Edit wrap: mode_date = 0, edit_sel = 1, up held 12 cycles from month 05 -> month 05 again, no `tick_year`; edit_sel = 0, down 1 cycle on day 01 in April -> day 30.
- Clamp: edit to 01/31, then month up -> 02/28 (year 2023) or 02/29 (year 2024); with date 02/29, change year 2024 -> 2025 -> 02/28 on the next edge.
- Simultaneous and ignored inputs: up = down = 1 for 10 cycles -> no change; `tick_day` = 1 in edit mode -> no change; `up` in run mode -> no change.

Source files
------------

// File: rtl/counter_days_months.sv
// counter_days_months
//
// Day-of-month and month counter for the Millennium Clock calendar chain. It sits
// between the daily tick source and counter_years. It advances the date on tick_day in
// run mode, stepping across month ends with leap-year awareness taken from the BCD year
// fed back by counter_years. On the Dec 31 -> Jan 1 rollover it emits a one-cycle
// tick_year pulse. In edit mode the user steps either the day or the month with up/down.
//
// Ports
//   clk            system clock, all state updates on the rising edge
//   rst_n          asynchronous active-low reset, release synchronous to clk
//   mode_date      1 = run (count tick_day), 0 = edit (up/down active)
//   edit_sel       edit target: 0 = day, 1 = month (edit mode only)
//   up / down      level inputs; step the edit target once per clock
//   tick_day       level input; advance one day per clock (run mode only)
//   year_*         BCD year digits from counter_years
//   day_unit/ten   BCD day of month (01..31)
//   month_unit/ten BCD month (01..12)
//   tick_year      registered one-cycle pulse on the year rollover
module counter_days_months #(
    parameter int unsigned DAY_INIT   = 1,
    parameter int unsigned MONTH_INIT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_date,
    input  logic       edit_sel,
    input  logic       up,
    input  logic       down,
    input  logic       tick_day,
    input  logic [3:0] year_unit,
    input  logic [3:0] year_ten,
    input  logic [3:0] year_hundered,
    input  logic [3:0] year_thousand,
    output logic [3:0] day_unit,
    output logic [3:0] day_ten,
    output logic [3:0] month_unit,
    output logic [3:0] month_ten,
    output logic       tick_year
);

    localparam logic [3:0] DayUnitInit   = 4'(DAY_INIT % 10);
    localparam logic [3:0] DayTenInit    = 4'(DAY_INIT / 10);
    localparam logic [3:0] MonthUnitInit = 4'(MONTH_INIT % 10);
    localparam logic [3:0] MonthTenInit  = 4'(MONTH_INIT / 10);

    // Two-digit BCD divisibility by 4: a multiple of 4 ends in 0/4/8 after an even
    // tens digit and in 2/6 after an odd one.
    function automatic logic bcd_div4(input logic [3:0] ten, input logic [3:0] unit);
        logic res;
        if (ten[0]) begin
            res = (unit == 4'd2) || (unit == 4'd6);
        end else begin
            res = (unit == 4'd0) || (unit == 4'd4) || (unit == 4'd8);
        end
        return res;
    endfunction

    function automatic logic [4:0] days_in_month(input logic [3:0] month, input logic leap);
        logic [4:0] dim;
        case (month)
            4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
            4'd2:                    dim = leap ? 5'd29 : 5'd28;
            default:                 dim = 5'd31;
        endcase
        return dim;
    endfunction

    // Binary 0..31 back to {tens, units} BCD.
    function automatic logic [7:0] to_bcd(input logic [4:0] v);
        logic [3:0] ten;
        logic [3:0] unit;
        if (v >= 5'd30) begin
            ten  = 4'd3;
            unit = 4'(v - 5'd30);
        end else if (v >= 5'd20) begin
            ten  = 4'd2;
            unit = 4'(v - 5'd20);
        end else if (v >= 5'd10) begin
            ten  = 4'd1;
            unit = 4'(v - 5'd10);
        end else begin
            ten  = 4'd0;
            unit = v[3:0];
        end
        return {ten, unit};
    endfunction

    logic [3:0] day_unit_q, day_unit_d;
    logic [3:0] day_ten_q, day_ten_d;
    logic [3:0] month_unit_q, month_unit_d;
    logic [3:0] month_ten_q, month_ten_d;
    logic       tick_year_q, tick_year_d;

    logic       yy_zero;
    logic       leap;
    logic [4:0] day_bin;
    logic [3:0] month_bin;
    logic [4:0] cur_dim;
    logic [4:0] new_dim;
    logic [4:0] day_n;
    logic [3:0] month_n;
    logic       step_up;
    logic       step_down;

    // Century years (yy == 00) are leap only when the century itself is divisible by 4.
    assign yy_zero = (year_ten == 4'd0) && (year_unit == 4'd0);
    assign leap    = yy_zero ? bcd_div4(year_thousand, year_hundered)
                             : bcd_div4(year_ten, year_unit);

    assign day_bin   = 5'(day_ten_q) * 5'd10 + 5'(day_unit_q);
    assign month_bin = month_ten_q * 4'd10 + month_unit_q;
    assign cur_dim   = days_in_month(month_bin, leap);

    assign step_up   = up && !down;
    assign step_down = down && !up;

    always_comb begin
        day_n       = day_bin;
        month_n     = month_bin;
        tick_year_d = 1'b0;
        new_dim     = 5'd31;

        if (mode_date) begin
            if (tick_day) begin
                // >= rather than == so a Feb 29 made invalid by a same-cycle year change
                // still rolls forward into March.
                if (day_bin < cur_dim) begin
                    day_n = day_bin + 5'd1;
                end else begin
                    day_n = 5'd1;
                    if (month_bin >= 4'd12) begin
                        month_n     = 4'd1;
                        tick_year_d = 1'b1;
                    end else begin
                        month_n = month_bin + 4'd1;
                    end
                end
            end
        end else if (step_up) begin
            if (!edit_sel) begin
                day_n = (day_bin >= cur_dim) ? 5'd1 : day_bin + 5'd1;
            end else begin
                month_n = (month_bin >= 4'd12) ? 4'd1 : month_bin + 4'd1;
            end
        end else if (step_down) begin
            if (!edit_sel) begin
                day_n = (day_bin <= 5'd1) ? cur_dim : day_bin - 5'd1;
            end else begin
                month_n = (month_bin <= 4'd1) ? 4'd12 : month_bin - 4'd1;
            end
        end

        // Clamp after the update: catches 31 -> 30-day month edits and Feb 29 in a
        // year that just stopped being leap.
        new_dim = days_in_month(month_n, leap);
        if (day_n > new_dim) begin
            day_n = new_dim;
        end

        {day_ten_d, day_unit_d}     = to_bcd(day_n);
        {month_ten_d, month_unit_d} = to_bcd({1'b0, month_n});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            day_unit_q   <= DayUnitInit;
            day_ten_q    <= DayTenInit;
            month_unit_q <= MonthUnitInit;
            month_ten_q  <= MonthTenInit;
            tick_year_q  <= 1'b0;
        end else begin
            day_unit_q   <= day_unit_d;
            day_ten_q    <= day_ten_d;
            month_unit_q <= month_unit_d;
            month_ten_q  <= month_ten_d;
            tick_year_q  <= tick_year_d;
        end
    end

    assign day_unit   = day_unit_q;
    assign day_ten    = day_ten_q;
    assign month_unit = month_unit_q;
    assign month_ten  = month_ten_q;
    assign tick_year  = tick_year_q;

endmodule

// File: tb/tb_counter_days_months.sv
// Self-checking bench for counter_days_months: a table of hand-computed vectors,
// directed multi-cycle corner sequences and a randomized run against a calendar model.
module tb_counter_days_months;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode_date, edit_sel, up, down, tick_day;
    logic [3:0] year_unit, year_ten, year_hundered, year_thousand;
    logic [3:0] day_unit, day_ten, month_unit, month_ten;
    logic       tick_year;

    int errors = 0;
    int checks = 0;
    int m_day, m_month, m_tick, year;

    always #5 clk = ~clk;

    counter_days_months dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mode_date    (mode_date),
        .edit_sel     (edit_sel),
        .up           (up),
        .down         (down),
        .tick_day     (tick_day),
        .year_unit    (year_unit),
        .year_ten     (year_ten),
        .year_hundered(year_hundered),
        .year_thousand(year_thousand),
        .day_unit     (day_unit),
        .day_ten      (day_ten),
        .month_unit   (month_unit),
        .month_ten    (month_ten),
        .tick_year    (tick_year)
    );

    typedef struct {
        bit mode, sel, u, d, t;
        int yr;
        int e_day, e_month, e_tick;
    } vec_t;

    // Gregorian rule in plain arithmetic.
    function automatic bit is_leap(input int y);
        return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    endfunction

    function automatic int days_in(input int mo, input int y);
        int t [12];
        t = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (mo == 2 && is_leap(y)) return 29;
        return t[mo - 1];
    endfunction

    // Packed as hex DD_MM_t for readable reports.
    function automatic logic [19:0] pack(input int d, input int mo, input int t);
        return {4'(d / 10), 4'(d % 10), 4'(mo / 10), 4'(mo % 10), 4'(t)};
    endfunction

    function automatic logic [19:0] dut_out();
        return {day_ten, day_unit, month_ten, month_unit, 3'b000, tick_year};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_year(input int y);
        year          = y;
        year_thousand = 4'(y / 1000);
        year_hundered = 4'((y / 100) % 10);
        year_ten      = 4'((y / 10) % 10);
        year_unit     = 4'(y % 10);
    endtask

    // Calendar model: one clock edge with the inputs currently applied.
    task automatic model_step();
        int dim;
        m_tick = 0;
        dim    = days_in(m_month, year);
        if (mode_date) begin
            if (tick_day) begin
                if (m_day < dim) begin
                    m_day++;
                end else begin
                    m_day = 1;
                    if (m_month == 12) begin
                        m_month = 1;
                        m_tick  = 1;
                    end else begin
                        m_month++;
                    end
                end
            end
        end else if (up && !down) begin
            if (!edit_sel) m_day = (m_day >= dim) ? 1 : m_day + 1;
            else           m_month = (m_month == 12) ? 1 : m_month + 1;
        end else if (down && !up) begin
            if (!edit_sel) m_day = (m_day <= 1) ? dim : m_day - 1;
            else           m_month = (m_month == 1) ? 12 : m_month - 1;
        end
        if (m_day > days_in(m_month, year)) m_day = days_in(m_month, year);
    endtask

    task automatic drive(input bit md, input bit sel, input bit u, input bit d, input bit t,
                         input string name);
        mode_date = md;
        edit_sel  = sel;
        up        = u;
        down      = d;
        tick_day  = t;
        model_step();
        @(posedge clk);
        #1;
        check(name, 32'(dut_out()), 32'(pack(m_day, m_month, m_tick)));
    endtask

    // Async assert with random inputs, then synchronous release into a quiet edit hold.
    task automatic do_reset();
        mode_date = 1'($urandom);
        edit_sel  = 1'($urandom);
        up        = 1'($urandom);
        down      = 1'($urandom);
        tick_day  = 1'($urandom);
        set_year(int'($urandom_range(1900, 2499)));
        #2;
        rst_n   = 1'b0;
        #1;
        m_day   = 1;
        m_month = 1;
        m_tick  = 0;
        check("reset_async", 32'(dut_out()), 32'(pack(1, 1, 0)));
        @(posedge clk);
        #1;
        check("reset_hold", 32'(dut_out()), 32'(pack(1, 1, 0)));
        mode_date = 1'b0;
        up        = 1'b0;
        down      = 1'b0;
        tick_day  = 1'b0;
        set_year(2023);
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t vecs[$];
        int   pulses, first_pulse, saw_feb29;
        int   leap_years[4];
        int   leap_day[4];
        int   leap_mon[4];
        int   yr_pool[7];

        rst_n     = 1'b1;
        mode_date = 1'b0;
        edit_sel  = 1'b0;
        up        = 1'b0;
        down      = 1'b0;
        tick_day  = 1'b0;
        set_year(2023);
        #3;

        // ---------------- table-driven vectors from 01/01 ----------------
        //               md sel u  d  t  year  day mon tick
        vecs.push_back('{1, 0, 0, 0, 1, 2023, 2,  1, 0});
        vecs.push_back('{1, 0, 0, 0, 0, 2023, 2,  1, 0});
        vecs.push_back('{0, 1, 1, 0, 0, 2023, 2,  2, 0});
        vecs.push_back('{0, 0, 0, 1, 0, 2023, 1,  2, 0});
        vecs.push_back('{0, 0, 0, 1, 0, 2023, 28, 2, 0});
        vecs.push_back('{0, 0, 1, 0, 0, 2023, 1,  2, 0});
        vecs.push_back('{0, 0, 0, 1, 0, 2024, 29, 2, 0});
        vecs.push_back('{0, 1, 1, 1, 0, 2024, 29, 2, 0});
        vecs.push_back('{0, 0, 0, 0, 1, 2024, 29, 2, 0});
        vecs.push_back('{1, 1, 1, 0, 0, 2024, 29, 2, 0});
        vecs.push_back('{1, 0, 0, 0, 1, 2024, 1,  3, 0});
        vecs.push_back('{0, 1, 0, 1, 0, 2024, 1,  2, 0});
        vecs.push_back('{0, 0, 0, 1, 0, 2024, 29, 2, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 2025, 28, 2, 0});
        vecs.push_back('{0, 1, 0, 1, 0, 2025, 28, 1, 0});
        vecs.push_back('{0, 0, 1, 0, 0, 2025, 29, 1, 0});
        vecs.push_back('{0, 1, 0, 1, 0, 2025, 29, 12, 0});
        vecs.push_back('{1, 0, 0, 0, 1, 2025, 30, 12, 0});
        vecs.push_back('{1, 0, 0, 0, 1, 2025, 31, 12, 0});
        vecs.push_back('{1, 0, 0, 0, 1, 2025, 1,  1, 1});
        vecs.push_back('{1, 0, 0, 0, 1, 2025, 2,  1, 0});

        do_reset();
        foreach (vecs[i]) begin
            mode_date = vecs[i].mode;
            edit_sel  = vecs[i].sel;
            up        = vecs[i].u;
            down      = vecs[i].d;
            tick_day  = vecs[i].t;
            set_year(vecs[i].yr);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), 32'(dut_out()),
                  32'(pack(vecs[i].e_day, vecs[i].e_month, vecs[i].e_tick)));
        end

        // ---------------- year rollover, 2023 and 2024 ----------------
        for (int k = 0; k < 2; k++) begin
            int n;
            n = (k == 0) ? 365 : 366;
            do_reset();
            set_year((k == 0) ? 2023 : 2024);
            pulses      = 0;
            first_pulse = -1;
            saw_feb29   = 0;
            for (int c = 1; c <= n; c++) begin
                drive(1, 0, 0, 0, 1, "roll_step");
                if (tick_year) begin
                    pulses++;
                    if (first_pulse < 0) first_pulse = c;
                end
                if ({day_ten, day_unit, month_ten, month_unit} == 16'h2902) saw_feb29 = 1;
            end
            check("roll_pulses", 32'(pulses), 32'd1);
            check("roll_pulse_edge", 32'(first_pulse), 32'(n));
            check("roll_date", 32'({day_ten, day_unit, month_ten, month_unit}), 32'h0101);
            check("roll_feb29_seen", 32'(saw_feb29), 32'(k));
            drive(1, 0, 0, 0, 0, "roll_after");
        end

        // ---------------- leap rules from Feb 28 ----------------
        leap_years = '{1900, 2000, 2100, 2400};
        leap_day   = '{1, 29, 1, 29};
        leap_mon   = '{3, 2, 3, 2};
        for (int k = 0; k < 4; k++) begin
            do_reset();
            drive(0, 1, 1, 0, 0, "leap_setup_m");
            drive(0, 0, 0, 1, 0, "leap_setup_d");
            set_year(leap_years[k]);
            drive(1, 0, 0, 0, 1, "leap_step");
            check($sformatf("leap_%0d", leap_years[k]), 32'(dut_out()),
                  32'(pack(leap_day[k], leap_mon[k], 0)));
        end

        // ---------------- edit wrap ----------------
        do_reset();
        for (int c = 0; c < 4; c++) drive(0, 1, 1, 0, 0, "wrap_to_may");
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            drive(0, 1, 1, 0, 0, "wrap_month");
            if (tick_year) pulses++;
        end
        check("wrap_month_05", 32'({month_ten, month_unit}), 32'h05);
        check("wrap_no_tick", 32'(pulses), 32'd0);
        drive(0, 1, 0, 1, 0, "wrap_to_april");
        drive(0, 0, 0, 1, 0, "wrap_day_down");
        check("wrap_april_30", 32'(dut_out()), 32'(pack(30, 4, 0)));

        // ---------------- clamp ----------------
        for (int k = 0; k < 2; k++) begin
            do_reset();
            set_year((k == 0) ? 2023 : 2024);
            drive(0, 0, 0, 1, 0, "clamp_to_31");
            check("clamp_jan31", 32'(dut_out()), 32'(pack(31, 1, 0)));
            drive(0, 1, 1, 0, 0, "clamp_month_up");
            check("clamp_feb", 32'(dut_out()), 32'(pack((k == 0) ? 28 : 29, 2, 0)));
        end
        set_year(2025);
        drive(0, 0, 0, 0, 0, "clamp_year_change");
        check("clamp_feb29_to_28", 32'(dut_out()), 32'(pack(28, 2, 0)));

        // ---------------- simultaneous / ignored inputs ----------------
        do_reset();
        for (int c = 0; c < 10; c++) drive(0, 1'($urandom), 1, 1, 0, "both_pressed");
        check("both_hold", 32'(dut_out()), 32'(pack(1, 1, 0)));
        for (int c = 0; c < 5; c++) drive(0, 1'($urandom), 0, 0, 1, "tick_in_edit");
        check("tick_edit_hold", 32'(dut_out()), 32'(pack(1, 1, 0)));
        for (int c = 0; c < 5; c++) drive(1, 1'($urandom), 1, 0, 0, "up_in_run");
        check("up_run_hold", 32'(dut_out()), 32'(pack(1, 1, 0)));

        // ---------------- async reset mid-count ----------------
        do_reset();
        for (int c = 0; c < 40; c++) drive(1, 0, 0, 0, 1, "pre_reset_count");
        check("pre_reset_date", 32'(dut_out()), 32'(pack(10, 2, 0)));
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_reset_async", 32'(dut_out()), 32'(pack(1, 1, 0)));
        m_day   = 1;
        m_month = 1;
        m_tick  = 0;
        @(posedge clk);
        #1;
        tick_day = 1'b0;
        rst_n    = 1'b1;

        // ---------------- randomized run against the model ----------------
        do_reset();
        yr_pool = '{1900, 2000, 2023, 2024, 2025, 2100, 2400};
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 49) == 0) set_year(yr_pool[$urandom_range(0, 6)]);
            drive(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) != 0), "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
